colour_decoder: RTL and testbench

COLOUR_DECODER -- requirements
Module: colour_decoder

---
 rtl/colour_decoder.sv | 173 +++++++++++++++++
 tb/tb_colour_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_decoder.sv
// Debounces four colour buttons and emits one 2-bit colour code per press; build with COLOUR_DEC_ERR_EN to reject multi-button presses.
// Latency: colour_valid rises DEBOUNCE_CYCLES+3 edges after btn_in changes (2 sync + capture + DEBOUNCE_CYCLES stable samples).
// Backpressure: colour_valid/colour_code hold until colour_ready; a press arriving while a code is still pending is dropped and sets sticky overrun.
module colour_decoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] btn_in,
    output logic [1:0] colour_code,
    output logic       colour_valid,
    input  logic       colour_ready,
    output logic       multi_err,
    output logic       overrun
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] code;
        logic       valid;
        logic       multi_err;
        logic       overrun;
    } out_t;

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    out_t             out_q, out_d;

    logic [3:0] s;
    logic       deb_done;
    logic       err_hit;
    logic       load;
    logic       fire;
    logic [1:0] enc;

    assign sync1_d = btn_in;
    assign sync2_d = sync1_q;
    assign s       = sync2_q;

    // State register: synchronizer, FSM, counter, candidate and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            out_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic; the counter saturates at CNT_LAST because every path
    // that reaches it leaves the counting state or clears it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        deb_done = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s != 4'b0000) begin
                        cand_d  = s;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (s == 4'b0000) begin
                        state_d = IDLE;
                    end else if (s != cand_q) begin
                        cand_d = s;
                        cnt_d  = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d  = PRESSED;
                        deb_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (s == 4'b0000) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (s != 4'b0000) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Lowest set index wins, so red has the highest priority.
    always_comb begin
        enc = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (cand_q[i]) enc = 2'(i);
        end
    end

`ifdef COLOUR_DEC_ERR_EN
    logic is_multi;
    assign is_multi = |(cand_q & (cand_q - 4'd1));
    assign err_hit  = deb_done & is_multi;
`else
    assign err_hit  = 1'b0;
`endif

    assign load = deb_done & ~err_hit;
    assign fire = out_q.valid & colour_ready;

    // Output logic: a load coinciding with a transfer replaces the code,
    // a load against a stalled code is dropped and recorded in overrun.
    always_comb begin
        out_d           = out_q;
        out_d.multi_err = err_hit;
        if (fire) out_d.valid = 1'b0;
        if (!ena) begin
            out_d.valid     = 1'b0;
            out_d.code      = 2'd0;
            out_d.multi_err = 1'b0;
        end else if (load) begin
            if (out_q.valid && !fire) begin
                out_d.overrun = 1'b1;
            end else begin
                out_d.valid = 1'b1;
                out_d.code  = enc;
            end
        end
    end

    assign colour_code  = out_q.code;
    assign colour_valid = out_q.valid;
    assign multi_err    = out_q.multi_err;
    assign overrun      = out_q.overrun;

endmodule

// File: tb/tb_colour_decoder.sv
// Self-checking bench for colour_decoder (DEBOUNCE_CYCLES=4): scenario table, directed corner sequences, random run against a reference model.
// Latency: checks sample outputs on the falling edge, half a cycle after each rising edge.
// Backpressure: colour_ready is driven per scenario and randomly in the model-checked run.
module tb_colour_decoder;

    localparam int D = 4;
`ifdef COLOUR_DEC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [3:0] btn_in = 4'b0000;
    logic       colour_ready = 1'b1;
    logic [1:0] colour_code;
    logic       colour_valid;
    logic       multi_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    colour_decoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .btn_in       (btn_in),
        .colour_code  (colour_code),
        .colour_valid (colour_valid),
        .colour_ready (colour_ready),
        .multi_err    (multi_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_in = 4'b0000;
        ena    = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs n cycles, accumulating valid cycles, last code seen and multi_err cycles.
    task automatic run_count(input int n, inout int pulses, inout logic [1:0] last_code, inout int errs);
        for (int k = 0; k < n; k++) begin
            tick();
            if (colour_valid) begin
                pulses++;
                last_code = colour_code;
            end
            if (multi_err) errs++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_s1, m_s2, m_cand;
    int         m_run, m_zeros;
    bit         m_held;
    logic [1:0] m_code;
    logic       m_valid, m_merr, m_ovr;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_cand = 0; m_run = 0; m_zeros = -1; m_held = 0;
        m_code = 0; m_valid = 0; m_merr = 0; m_ovr = 0;
    endtask

    // Two phases: waiting for a press (m_cand==0 means nothing seen yet) and
    // waiting for release (m_zeros<0 means no zero sample seen yet).
    task automatic model_step(input logic [3:0] b, input logic en, input logic rdy);
        logic [3:0] s;
        logic fire, accept, was_valid;
        s = m_s2; m_s2 = m_s1; m_s1 = b;
        was_valid = m_valid;
        fire = m_valid & rdy;
        accept = 1'b0;
        m_merr = 1'b0;
        if (!en) begin
            m_held = 0; m_cand = 0; m_run = 0; m_valid = 0; m_code = 0;
        end else begin
            if (!m_held) begin
                if (s == 0) m_cand = 0;
                else if (s != m_cand) begin m_cand = s; m_run = 0; end
                else if (m_run == D - 1) begin accept = 1'b1; m_held = 1; m_zeros = -1; end
                else m_run++;
            end else begin
                if (s == 0) begin
                    if (m_zeros < 0) m_zeros = 0;
                    else if (m_zeros == D - 1) begin m_held = 0; m_cand = 0; end
                    else m_zeros++;
                end else if (m_zeros >= 0) m_zeros = 0;
            end
            if (fire) m_valid = 1'b0;
            if (accept) begin
                if (ERR_EN && $countones(m_cand) > 1) m_merr = 1'b1;
                else if (was_valid && !fire) m_ovr = 1'b1;
                else begin m_valid = 1'b1; m_code = lowest(m_cand); end
            end
        end
    endtask

    function automatic logic [3:0] rand_btn();
        logic [3:0] v;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3) return 4'b0000;
        if (sel < 8) begin
            v = 4'b0001 << $urandom_range(0, 3);
            return v;
        end
        do v = 4'($urandom_range(0, 15)); while ($countones(v) < 2);
        return v;
    endfunction

    // ---------------- scenario table ----------------
    typedef struct {
        logic [3:0] btn;
        int         exp_pulses;
        logic [1:0] exp_code;
        int         exp_errs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p, e;
        logic [1:0] c;

        vecs[0] = '{4'b0001, 1, 2'd0, 0};
        vecs[1] = '{4'b0010, 1, 2'd1, 0};
        vecs[2] = '{4'b0100, 1, 2'd2, 0};
        vecs[3] = '{4'b1000, 1, 2'd3, 0};
        if (ERR_EN) begin
            vecs[4] = '{4'b0011, 0, 2'd0, 1};
            vecs[5] = '{4'b1100, 0, 2'd0, 1};
            vecs[6] = '{4'b1110, 0, 2'd0, 1};
        end else begin
            vecs[4] = '{4'b0011, 1, 2'd0, 0};
            vecs[5] = '{4'b1100, 1, 2'd2, 0};
            vecs[6] = '{4'b1110, 1, 2'd1, 0};
        end

        // Asynchronous reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        check("reset_valid", colour_valid, 0);
        check("reset_code", colour_code, 0);
        check("reset_multi_err", multi_err, 0);
        check("reset_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: hold each pattern long enough for one press, then release.
        foreach (vecs[i]) begin
            do_reset();
            colour_ready = 1'b1;
            btn_in = vecs[i].btn;
            p = 0; e = 0; c = 2'd0;
            run_count(D + 10, p, c, e);
            btn_in = 4'b0000;
            run_count(D + 6, p, c, e);
            check($sformatf("tbl%0d_pulses", i), p, vecs[i].exp_pulses);
            check($sformatf("tbl%0d_code", i), c, vecs[i].exp_code);
            check($sformatf("tbl%0d_multi_err", i), e, vecs[i].exp_errs);
            check($sformatf("tbl%0d_overrun", i), overrun, 0);
        end

        // Exact latency: valid after edge 7 only, single pulse while held.
        do_reset();
        colour_ready = 1'b1;
        btn_in = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("lat_valid_edge%0d", k), colour_valid, (k == D + 3) ? 1 : 0);
            if (k == D + 3) check("lat_code", colour_code, 2'd2);
        end
        p = 0; e = 0; c = 2'd0;
        run_count(10, p, c, e);
        check("lat_no_repeat", p, 0);
        btn_in = 4'b0000;

        // Bounce every 2 cycles must never load; settling gives one code.
        do_reset();
        p = 0; e = 0; c = 2'd0;
        for (int k = 0; k < 10; k++) begin
            btn_in = 4'b0010;
            run_count(2, p, c, e);
            btn_in = 4'b0000;
            run_count(2, p, c, e);
        end
        check("bounce_no_valid", p, 0);
        btn_in = 4'b0010;
        run_count(14, p, c, e);
        check("bounce_settled_pulses", p, 1);
        check("bounce_settled_code", c, 2'd1);
        btn_in = 4'b0000;
        run_count(8, p, c, e);

        // Stalled consumer: green held, red dropped, overrun set.
        do_reset();
        colour_ready = 1'b0;
        btn_in = 4'b1000; run_count(10, p, c, e);
        btn_in = 4'b0000; run_count(10, p, c, e);
        btn_in = 4'b0001; run_count(10, p, c, e);
        btn_in = 4'b0000; run_count(10, p, c, e);
        check("ovr_valid_held", colour_valid, 1);
        check("ovr_code_green", colour_code, 2'd3);
        check("ovr_flag", overrun, 1);
        colour_ready = 1'b1;
        tick();
        check("ovr_after_xfer_valid", colour_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Reset mid-debounce.
        do_reset();
        colour_ready = 1'b1;
        btn_in = 4'b0001;
        p = 0; e = 0; c = 2'd0;
        run_count(5, p, c, e);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_deb_valid", colour_valid, 0);
        check("rst_mid_deb_code", colour_code, 0);
        btn_in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        run_count(12, p, c, e);
        check("rst_mid_deb_no_output", p, 0);

        // Reset while a code is pending.
        colour_ready = 1'b0;
        btn_in = 4'b0100;
        run_count(10, p, c, e);
        check("rst_pending_pre_valid", colour_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pending_valid", colour_valid, 0);
        check("rst_pending_code", colour_code, 0);
        btn_in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        p = 0;
        run_count(12, p, c, e);
        check("rst_pending_no_output", p, 0);
        check("rst_pending_overrun", overrun, 0);

        // ena low during a held press; overrun survives.
        do_reset();
        colour_ready = 1'b0;
        btn_in = 4'b0010; run_count(10, p, c, e);
        btn_in = 4'b0000; run_count(10, p, c, e);
        btn_in = 4'b0001; run_count(10, p, c, e);
        check("ena_pre_code", colour_code, 2'd1);
        check("ena_pre_overrun", overrun, 1);
        ena = 1'b0;
        tick();
        check("ena_off_valid", colour_valid, 0);
        check("ena_off_code", colour_code, 0);
        check("ena_off_overrun", overrun, 1);
        btn_in = 4'b0000;
        run_count(6, p, c, e);
        ena = 1'b1;
        colour_ready = 1'b1;
        p = 0;
        run_count(10, p, c, e);
        check("ena_back_no_code", p, 0);
        btn_in = 4'b1000;
        run_count(12, p, c, e);
        check("ena_new_press_pulses", p, 1);
        check("ena_new_press_code", c, 2'd3);
        btn_in = 4'b0000;
        run_count(8, p, c, e);

        // Random run checked cycle by cycle against the model.
        do_reset();
        model_reset();
        begin
            int hold;
            hold = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (hold == 0) begin
                    btn_in = rand_btn();
                    hold = $urandom_range(1, 12);
                end
                hold--;
                ena = ($urandom_range(0, 99) >= 3);
                colour_ready = ($urandom_range(0, 2) != 0);
                @(posedge clk);
                model_step(btn_in, ena, colour_ready);
                @(negedge clk);
                check($sformatf("rand_cyc%0d {code,valid,merr,ovr}", cyc),
                      {colour_code, colour_valid, multi_err, overrun},
                      {m_code, m_valid, m_merr, m_ovr});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
